// File: rtl/regfile_rd2_wr1.sv
// regfile_rd2_wr1: 2**ADDR_W x DATA_W register file with one write port and
// two synchronous read ports. Register 0 is hardwired to zero. Reads complete
// in one cycle with an optional write-to-read bypass. There is no back-pressure.
//
// Ports:
//   clk, clr              clock; asynchronous active-high clear of all state
//   we, waddr, wdata      write port (a write to address 0 is discarded)
//   re_a, raddr_a         read request, port A
//   re_b, raddr_b         read request, port B
//   rdata_a, rvalid_a     registered read data and one-cycle valid pulse, port A
//   rdata_b, rvalid_b     registered read data and one-cycle valid pulse, port B
module regfile_rd2_wr1 #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic              rvalid_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              rvalid_b
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  wen;
  logic [DATA_W-1:0] next_a;
  logic [DATA_W-1:0] next_b;

  // One-hot per-register write enable. Bit 0 is never set, so regs[0] only
  // ever holds its reset value of zero.
  always_comb begin
    wen = '0;
    for (int i = 1; i < DEPTH; i++) begin
      wen[i] = we && (waddr == ADDR_W'(i));
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wen[i]) begin
          regs[i] <= wdata;
        end
      end
    end
  end

  // Read data selection. Address 0 is forced to zero explicitly.
  // With bypass enabled, a same-edge write to the read address wins over the
  // stored (pre-edge) contents.
  always_comb begin
    next_a = regs[raddr_a];
    if (raddr_a == '0) begin
      next_a = '0;
    end else if ((BYPASS != 0) && we && (waddr == raddr_a)) begin
      next_a = wdata;
    end
  end

  always_comb begin
    next_b = regs[raddr_b];
    if (raddr_b == '0) begin
      next_b = '0;
    end else if ((BYPASS != 0) && we && (waddr == raddr_b)) begin
      next_b = wdata;
    end
  end

  // Read data is held while the port is idle. The valid flag follows the
  // request with one cycle of delay.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rdata_a  <= '0;
      rdata_b  <= '0;
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
    end else begin
      rvalid_a <= re_a;
      rvalid_b <= re_b;
      if (re_a) begin
        rdata_a <= next_a;
      end
      if (re_b) begin
        rdata_b <= next_b;
      end
    end
  end

endmodule

// File: tb/tb_regfile_rd2_wr1.sv
// Testbench for regfile_rd2_wr1. It drives one instance with BYPASS=1 and one
// with BYPASS=0 from the same inputs, and compares both against an array model.
module tb_regfile_rd2_wr1;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic        re_a = 1'b0;
  logic [4:0]  raddr_a = '0;
  logic        re_b = 1'b0;
  logic [4:0]  raddr_b = '0;

  logic [31:0] rd_a1, rd_b1, rd_a0, rd_b0;
  logic        rv_a1, rv_b1, rv_a0, rv_b0;

  always #5 clk = ~clk;

  regfile_rd2_wr1 #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut_byp (
    .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .re_b(re_b), .raddr_b(raddr_b),
    .rdata_a(rd_a1), .rvalid_a(rv_a1), .rdata_b(rd_b1), .rvalid_b(rv_b1)
  );

  regfile_rd2_wr1 #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_nobyp (
    .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .re_b(re_b), .raddr_b(raddr_b),
    .rdata_a(rd_a0), .rvalid_a(rv_a0), .rdata_b(rd_b0), .rvalid_b(rv_b0)
  );

  // Reference model
  logic [31:0] mem [32];
  logic [31:0] ea1 = '0, eb1 = '0, ea0 = '0, eb0 = '0;
  logic        eva = 1'b0, evb = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [4:0] a, input bit byp);
    if (a == 0) return 32'h0;
    if (byp && we && waddr == a) return wdata;
    return mem[a];
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "_rdata_a_byp"},  rd_a1, ea1);
    chk({tag, "_rdata_b_byp"},  rd_b1, eb1);
    chk({tag, "_rdata_a_nbyp"}, rd_a0, ea0);
    chk({tag, "_rdata_b_nbyp"}, rd_b0, eb0);
    chk({tag, "_rvalid_a"}, {31'b0, rv_a1}, {31'b0, eva});
    chk({tag, "_rvalid_b"}, {31'b0, rv_b1}, {31'b0, evb});
    chk({tag, "_rvalid_a_nbyp"}, {31'b0, rv_a0}, {31'b0, eva});
    chk({tag, "_rvalid_b_nbyp"}, {31'b0, rv_b0}, {31'b0, evb});
  endtask

  // Drive one cycle of inputs, advance the model across the edge, and check
  // the outputs 1 ns after the edge.
  task automatic step(input string tag, input logic w, input logic [4:0] wa,
                      input logic [31:0] wd, input logic ra, input logic [4:0] aa,
                      input logic rb, input logic [4:0] ab);
    we = w; waddr = wa; wdata = wd;
    re_a = ra; raddr_a = aa; re_b = rb; raddr_b = ab;
    if (ra) begin ea1 = model_rd(aa, 1'b1); ea0 = model_rd(aa, 1'b0); end
    if (rb) begin eb1 = model_rd(ab, 1'b1); eb0 = model_rd(ab, 1'b0); end
    eva = ra; evb = rb;
    if (w && wa != 0) mem[wa] = wd;
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mem[i] = '0;
    ea1 = '0; eb1 = '0; ea0 = '0; eb0 = '0; eva = 1'b0; evb = 1'b0;
  endtask

  initial begin
    model_clear();
    // Reset state while clr is held.
    #12;
    check_all("reset");
    @(negedge clk);
    clr = 1'b0;

    // Populate some registers, then clear asynchronously between edges.
    step("pre_w1", 1'b1, 5'd3, 32'h11112222, 1'b0, 5'd0, 1'b0, 5'd0);
    step("pre_rd", 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd3);
    chk("pre_rd_r3", rd_a1, 32'h11112222);
    #1;               // clk is high, with no edge before the next fall
    clr = 1'b1;
    #1;
    model_clear();
    check_all("async_clr");
    @(negedge clk);
    clr = 1'b0;

    // Every address reads zero after the reset.
    for (int i = 0; i < 32; i++) begin
      step("rd_zero", 1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 1'b1, 5'(31 - i));
      chk("rd_zero_a", rd_a1, 32'h0);
      chk("rd_zero_valid", {31'b0, rv_a1}, 32'h1);
    end

    // Write followed by read, and the neighbouring registers stay zero.
    step("w_r5", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0);
    step("r_r5", 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd0);
    chk("wr_rd_r5", rd_a1, 32'hDEADBEEF);
    chk("wr_rd_r5_valid", {31'b0, rv_a1}, 32'h1);
    step("r_r4_r6", 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b1, 5'd6);
    chk("r4_zero", rd_a1, 32'h0);
    chk("r6_zero", rd_b1, 32'h0);

    // A write to r0 is discarded.
    step("w_r0", 1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 1'b0, 5'd0);
    step("r_r0", 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd0);
    chk("r0_a", rd_a1, 32'h0);
    chk("r0_b", rd_b1, 32'h0);

    // Bypass on both ports at once.
    step("w_r7", 1'b1, 5'd7, 32'h00000001, 1'b0, 5'd0, 1'b0, 5'd0);
    step("byp", 1'b1, 5'd7, 32'hCAFEF00D, 1'b1, 5'd7, 1'b1, 5'd7);
    chk("byp1_a", rd_a1, 32'hCAFEF00D);
    chk("byp1_b", rd_b1, 32'hCAFEF00D);
    chk("byp0_a", rd_a0, 32'h00000001);
    chk("byp0_b", rd_b0, 32'h00000001);
    step("byp_after", 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd7);
    chk("byp0_after_a", rd_a0, 32'hCAFEF00D);

    // Read data holds while the port is idle, and valid toggles with requests.
    step("hold_rd", 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd7);
    for (int i = 0; i < 3; i++) begin
      step("hold", 1'b1, 5'd5, 32'h0BADF00D, 1'b0, 5'd5, (i % 2) == 1, 5'd6);
      chk("hold_data", rd_a1, 32'hDEADBEEF);
      chk("hold_valid", {31'b0, rv_a1}, 32'h0);
      chk("toggle_valid_b", {31'b0, rv_b1}, ((i % 2) == 1) ? 32'h1 : 32'h0);
    end

    // Reset mid-operation: the write and the read in the clr cycle are lost.
    step("w_r9", 1'b1, 5'd9, 32'h00001234, 1'b0, 5'd0, 1'b0, 5'd0);
    @(negedge clk);
    we = 1'b1; waddr = 5'd9; wdata = 32'hAAAA5555;
    re_a = 1'b1; raddr_a = 5'd9; re_b = 1'b0;
    #2;
    clr = 1'b1;
    @(posedge clk);
    #1;
    model_clear();
    check_all("clr_midop");
    @(negedge clk);
    clr = 1'b0;
    idle("post_clr");
    chk("post_clr_no_valid", {31'b0, rv_a1}, 32'h0);
    step("r_r9", 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd9);
    chk("r9_lost", rd_a1, 32'h0);

    // Randomized traffic with address collisions favoured.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] wa, aa, ab;
      wa = 5'($urandom_range(0, 31));
      aa = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      ab = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      step("rand", 1'($urandom), wa, $urandom, 1'($urandom), aa, 1'($urandom), ab);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
